booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
Iterative radix-4 Booth multiplier. It processes one Booth digit per clock and uses a start/done handshake. It is parametrised in operand width and selects signed or unsigned operation per request. It is the multi-cycle successor to the combinational product path feeding the datapath's HI/LO registers: it trades latency for area and adds an unsigned mode.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and ≥ 4.
- N (derived, localparam), WIDTH/2+1, number of Booth digits processed per operation.

Ports:
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high from the cycle after an accepted start until done falls
- done  output  1  single-cycle completion pulse
- z  output  2*WIDTH  product, registered; holds until the next completion

Behaviour:
- Reset is asynchronous and active-low. While clr_n=0, the block is in IDLE with busy=0, done=0, z=0, and all internal registers at 0. Deassertion is synchronous to clk.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=1, done=1. Lasts exactly one cycle, then returns to IDLE.
- IDLE→RUN when start=1 on a clock edge. At that edge:
  - Extend a and b to WIDTH+2 bits: sign-extend if is_signed=1, zero-extend if is_signed=0.
  - Load the multiplicand into a 2*WIDTH+4-bit register (same extension).
  - Load the multiplier with an appended 0 as bit -1.
  - Clear the accumulator and the digit counter.
- Each edge in RUN:
  - Form the digit from multiplier bits {b[2i+1], b[2i], b[2i-1]}.
  - Select the partial product: 000/111→0, 001/010→+M, 011→+2M, 100→−2M, 101/110→−M.
  - −M is the two's complement of M at full accumulator width.
  - Add the partial product to the accumulator modulo 2^(2*WIDTH+4).
  - Shift M left 2, shift the multiplier right 2, and increment the counter.
- RUN→DONE on the edge that processes digit N−1. At that same edge, z ← accumulator[2*WIDTH−1:0].
- Latency: if start is sampled at edge E0, done is high in the cycle following edge E0+N (N=17 for WIDTH=32), and z is valid in that same cycle.
- Result is exact:
  - Signed mode: the 2*WIDTH-bit two's-complement product.
  - Unsigned mode: the 2*WIDTH-bit unsigned product. There is no overflow in either mode.
- start is ignored in RUN and DONE; no queueing. A start sampled in the first IDLE cycle after DONE is accepted, giving back-to-back throughput of one result per N+2 cycles.
- a, b, and is_signed may change freely after the accepting edge without affecting the result in progress.
- z is updated only at RUN→DONE. It is not cleared when a new operation starts.
- clr_n asserted mid-operation aborts the operation immediately. All outputs go to their reset values, and no done pulse is produced for the aborted request.
- Zero operands run the full N cycles; there is no early termination.

Test Plan:
- WIDTH=32, is_signed=1, a=5, b=−3 (0xFFFFFFFD) → done high exactly 17 edges after start, busy high 18 cycles, z=0xFFFFFFFF_FFFFFFF1.
- WIDTH=32, a=b=0xFFFFFFFF: is_signed=0 → z=0xFFFFFFFE_00000001; then is_signed=1 → z=0x00000000_00000001.
- WIDTH=32, is_signed=1, a=b=0x80000000 → z=0x40000000_00000000. Also is_signed=1, a=0x7FFFFFFF, b=0x80000000 → z=0xC0000000_80000000.
- Pulse start again mid-RUN with different operands → ignored; the first result completes unchanged. Start asserted in the cycle right after done → accepted, and its result is correct.
- Assert clr_n=0 at digit 8 of an operation → busy, done, and z go to 0 asynchronously, with no done pulse. After release, a new start with a=3, b=7 unsigned → z=21.
- WIDTH=8 instance:
  - is_signed=1, a=0x80 (−128), b=0x7F (127) → z=0xC080, done 5 edges after start.
  - is_signed=0, a=0xFF, b=0xFF → z=0xFE01.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, start/done handshake,
// signed or unsigned operands selected per request.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    localparam int unsigned N  = WIDTH / 2 + 1;
    localparam int unsigned AW = 2 * WIDTH + 4;
    localparam int unsigned BW = WIDTH + 3;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     m_q;
    logic [BW-1:0]     mult_q;
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     acc_d;
    logic [AW-1:0]     pp;
    logic [CW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] z_q;
    logic              last_digit;
    logic              a_ext_bit;
    logic              b_ext_bit;

    assign a_ext_bit  = is_signed & a[WIDTH-1];
    assign b_ext_bit  = is_signed & b[WIDTH-1];
    assign last_digit = (cnt_q == CW'(N - 1));

    // Booth digit {b[2i+1], b[2i], b[2i-1]} always sits in the low three multiplier bits.
    always_comb begin
        pp = '0;
        unique case (mult_q[2:0])
            3'b001, 3'b010: pp = m_q;
            3'b011:         pp = m_q << 1;
            3'b100:         pp = -(m_q << 1);
            3'b101, 3'b110: pp = -m_q;
            default:        pp = '0;
        endcase
        acc_d = acc_q + pp;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (last_digit) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_q    <= '0;
            mult_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            z_q    <= '0;
        end else if (state_q == StIdle && start) begin
            m_q    <= {{(AW - WIDTH){a_ext_bit}}, a};
            mult_q <= {{2{b_ext_bit}}, b, 1'b0};
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (state_q == StRun) begin
            acc_q  <= acc_d;
            m_q    <= m_q << 2;
            mult_q <= mult_q >> 2;
            cnt_q  <= cnt_q + CW'(1);
            if (last_digit) begin
                z_q <= acc_d[2*WIDTH-1:0];
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign z    = z_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed and random operations on WIDTH=32 and
// WIDTH=8 instances against a plain-arithmetic product model.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start32, sg32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] z32;
    logic        start8, sg8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start32),
        .is_signed (sg32),
        .a         (a32),
        .b         (b32),
        .busy      (busy32),
        .done      (done32),
        .z         (z32)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start8),
        .is_signed (sg8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .z         (z8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        return ux * uy;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
        int px;
        if (s) px = int'($signed(x)) * int'($signed(y));
        else   px = int'({24'b0, x}) * int'({24'b0, y});
        return px[15:0];
    endfunction

    // One WIDTH=32 operation; inject pulses start with other operands mid-run.
    task automatic op32(input logic [31:0] ai, input logic [31:0] bi, input logic s,
                        input logic inject, input string tag);
        int k;
        int busy_cnt;
        logic [63:0] exp;
        exp = ref32(ai, bi, s);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {63'b0, busy32}, 64'd0);
        chk({tag, "_idle_done"}, {63'b0, done32}, 64'd0);
        a32 = ai; b32 = bi; sg32 = s; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sg32 = ~s;
        k = 0;
        busy_cnt = 0;
        while (!done32 && k < 40) begin
            if (busy32) busy_cnt++;
            start32 = (inject && k == 5);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        start32 = 1'b0;
        if (busy32) busy_cnt++;
        chk({tag, "_latency"}, 64'(k), 64'd17);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd18);
        chk({tag, "_z"}, z32, exp);
    endtask

    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic s,
                       input string tag);
        int k;
        logic [15:0] exp;
        exp = ref8(ai, bi, s);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {63'b0, busy8}, 64'd0);
        a8 = ai; b8 = bi; sg8 = s; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        k = 0;
        while (!done8 && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(k), 64'd5);
        chk({tag, "_z"}, {48'b0, z8}, {48'b0, exp});
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;
        clr_n = 1'b0;
        start32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0;  sg8 = 1'b0;  a8 = '0;  b8 = '0;
        #2;
        chk("rst_busy", {63'b0, busy32}, 64'd0);
        chk("rst_done", {63'b0, done32}, 64'd0);
        chk("rst_z", z32, 64'd0);
        chk("rst_z8", {48'b0, z8}, 64'd0);
        @(negedge clk);
        clr_n = 1'b1;

        op32(32'd5, 32'hFFFF_FFFD, 1'b1, 1'b0, "s5xm3");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "u_max");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_m1");
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "s_min2");
        op32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "s_maxmin");
        op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, "inject");
        // Called right after done: start lands in the first IDLE cycle.
        op32(32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0, "b2b_zero");

        // Abort at digit 8 with a reset pulse.
        @(negedge clk);
        a32 = 32'hCAFE_F00D; b32 = 32'h1357_9BDF; sg32 = 1'b1; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy32}, 64'd0);
        chk("abort_done", {63'b0, done32}, 64'd0);
        chk("abort_z", z32, 64'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done32) done_seen++;
        end
        clr_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done32 || busy32) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        op32(32'd3, 32'd7, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            op32(ra, rb, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd32_%0d", i));
        end

        op8(8'h80, 8'h7F, 1'b1, "w8_s");
        op8(8'hFF, 8'hFF, 1'b0, "w8_u");
        for (int i = 0; i < 10; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            op8(ra8, rb8, 1'($urandom_range(0, 1)), $sformatf("rnd8_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
